// File: rtl/button_event_unit.sv
// Two-button event generator: per-button press/hold-repeat/release FSMs feeding
// a 4-entry event FIFO with sticky overflow on dropped events.
module button_event_unit #(
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn0,
  input  logic       btn1,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic [2:0] evt_count,
  output logic [1:0] press_pulse,
  output logic [1:0] release_pulse,
  output logic       overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic [25:0] HOLD_LIM   = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] REPEAT_LIM = 26'(REPEAT_CYCLES - 1);

  state_t [1:0]       state_r, state_s;
  logic [1:0][25:0]   cnt_r, cnt_s;
  logic [1:0]         btn_s, btn_q_r;
  logic [1:0]         ev_vld_s, press_s, release_s;
  logic [1:0][2:0]    ev_code_s;

  logic [3:0][2:0]    mem_r, mem_s;
  logic [1:0]         wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [2:0]         count_r, count_s, space_s, push_n_s;
  logic               pop_s, acc0_s, acc1_s, drop_s, ovf_s, valid_s;
  logic [2:0]         head_s;
  logic [1:0]         press_pulse_r, release_pulse_r;
  logic               evt_valid_r, overflow_r;
  logic [2:0]         evt_code_r;

  assign btn_s = {btn1, btn0};

  // Per-button next-state, counter and event generation.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_s[i]   = state_r[i];
      cnt_s[i]     = cnt_r[i];
      ev_vld_s[i]  = 1'b0;
      ev_code_s[i] = 3'b000;
      press_s[i]   = 1'b0;
      release_s[i] = 1'b0;
      case (state_r[i])
        ST_IDLE: begin
          if (btn_s[i] && !btn_q_r[i]) begin
            state_s[i]   = ST_HELD;
            cnt_s[i]     = 26'd0;
            ev_vld_s[i]  = 1'b1;
            ev_code_s[i] = {2'b01, 1'(i)};
            press_s[i]   = 1'b1;
          end else begin
            cnt_s[i] = 26'd0;
          end
        end
        ST_HELD, ST_REPEAT: begin
          // Release outranks a repeat landing on the same cycle.
          if (!btn_s[i]) begin
            state_s[i]   = ST_IDLE;
            cnt_s[i]     = 26'd0;
            ev_vld_s[i]  = 1'b1;
            ev_code_s[i] = {2'b10, 1'(i)};
            release_s[i] = 1'b1;
          end else if (cnt_r[i] == ((state_r[i] == ST_HELD) ? HOLD_LIM : REPEAT_LIM)) begin
            state_s[i]   = ST_REPEAT;
            cnt_s[i]     = 26'd0;
            ev_vld_s[i]  = 1'b1;
            ev_code_s[i] = {2'b11, 1'(i)};
          end else begin
            cnt_s[i] = cnt_r[i] + 26'd1;
          end
        end
        default: begin
          state_s[i] = ST_IDLE;
          cnt_s[i]   = 26'd0;
        end
      endcase
    end
  end

  // FIFO admission, pointer/occupancy update and next head value.
  always_comb begin
    pop_s   = evt_valid_r & evt_ready;
    space_s = 3'd4 - count_r + {2'b00, pop_s};
    if (space_s >= 3'd2) begin
      acc0_s = ev_vld_s[0];
      acc1_s = ev_vld_s[1];
    end else if (space_s == 3'd1) begin
      acc0_s = ev_vld_s[0];
      acc1_s = ev_vld_s[1] & ~ev_vld_s[0];
    end else begin
      acc0_s = 1'b0;
      acc1_s = 1'b0;
    end
    drop_s   = (ev_vld_s[0] & ~acc0_s) | (ev_vld_s[1] & ~acc1_s);
    push_n_s = {2'b00, acc0_s} + {2'b00, acc1_s};
    mem_s    = mem_r;
    if (acc0_s) begin
      mem_s[wr_ptr_r] = ev_code_s[0];
    end else begin
      mem_s[wr_ptr_r] = mem_r[wr_ptr_r];
    end
    if (acc1_s) begin
      mem_s[wr_ptr_r + {1'b0, acc0_s}] = ev_code_s[1];
    end else begin
      mem_s[wr_ptr_r + {1'b0, acc0_s}] = mem_s[wr_ptr_r + {1'b0, acc0_s}];
    end
    wr_ptr_s = wr_ptr_r + push_n_s[1:0];
    rd_ptr_s = rd_ptr_r + {1'b0, pop_s};
    count_s  = count_r + push_n_s - {2'b00, pop_s};
    valid_s  = (count_s != 3'd0);
    if (valid_s) begin
      head_s = mem_s[rd_ptr_s];
    end else begin
      head_s = 3'b000;
    end
    if (drop_s) begin
      ovf_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = overflow_r;
    end
  end

  // State, FIFO and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r[0]      <= ST_IDLE;
      state_r[1]      <= ST_IDLE;
      cnt_r           <= {2{26'd0}};
      btn_q_r         <= 2'b00;
      mem_r           <= {4{3'b000}};
      wr_ptr_r        <= 2'd0;
      rd_ptr_r        <= 2'd0;
      count_r         <= 3'd0;
      evt_valid_r     <= 1'b0;
      evt_code_r      <= 3'b000;
      press_pulse_r   <= 2'b00;
      release_pulse_r <= 2'b00;
      overflow_r      <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      btn_q_r         <= btn_s;
      mem_r           <= mem_s;
      wr_ptr_r        <= wr_ptr_s;
      rd_ptr_r        <= rd_ptr_s;
      count_r         <= count_s;
      evt_valid_r     <= valid_s;
      evt_code_r      <= head_s;
      press_pulse_r   <= press_s;
      release_pulse_r <= release_s;
      overflow_r      <= ovf_s;
    end
  end

  assign evt_valid     = evt_valid_r;
  assign evt_code      = evt_code_r;
  assign evt_count     = count_r;
  assign press_pulse   = press_pulse_r;
  assign release_pulse = release_pulse_r;
  assign overflow      = overflow_r;

endmodule
